// File: rtl/mem_copy_engine_if.sv
// Command, status and data-memory bus of the word-copy engine.
// The engine attaches through the slave modport; the requester and memory side use master.
interface mem_copy_engine_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH:0]   words_done;
   logic                  enable_read;
   logic                  enable_write;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output start, src_addr, dst_addr, length, read_data,
      input  busy, done, words_done, enable_read, enable_write, ram_addr, write_data
   );

   modport slave (
      input  start, src_addr, dst_addr, length, read_data,
      output busy, done, words_done, enable_read, enable_write, ram_addr, write_data
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Forward word-copy engine: alternates one READ and one WRITE cycle per word
// against a synchronous single-port data memory, then pulses done.
module mem_copy_engine #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   mem_copy_engine_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_index;
   logic [ADDR_WIDTH:0]   r_words_done;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_en_rd;
   logic                  r_en_wr;
   logic [ADDR_WIDTH-1:0] r_ram_addr;

   logic [ADDR_WIDTH:0]   w_next_index;

   assign w_next_index = r_index + ONE;

   // NOTE: all state, including the registered bus outputs, is cleared by the
   // async reset so the memory strobes drop the instant reset_n falls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
         r_index      <= '0;
         r_words_done <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_en_rd      <= 1'b0;
         r_en_wr      <= 1'b0;
         r_ram_addr   <= '0;
      end else begin
         // NOTE: non-blocking assignments only; every branch reads the
         // pre-edge values, so ordering inside the case does not matter.
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_src        <= bus.src_addr;
                  r_dst        <= bus.dst_addr;
                  r_len        <= bus.length;
                  r_index      <= '0;
                  r_words_done <= '0;
                  if (bus.length == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= READ;
                     r_busy     <= 1'b1;
                     r_en_rd    <= 1'b1;
                     r_ram_addr <= bus.src_addr;
                  end
               end
            end
            READ: begin
               r_state    <= WRITE;
               r_en_rd    <= 1'b0;
               r_en_wr    <= 1'b1;
               r_ram_addr <= r_dst + r_index[ADDR_WIDTH-1:0];
            end
            WRITE: begin
               r_index      <= w_next_index;
               r_words_done <= r_words_done + ONE;
               r_en_wr      <= 1'b0;
               if (w_next_index < r_len) begin
                  r_state    <= READ;
                  r_en_rd    <= 1'b1;
                  r_ram_addr <= r_src + w_next_index[ADDR_WIDTH-1:0];
               end else begin
                  r_state    <= DONE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_ram_addr <= '0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read data only arrives during WRITE, so it passes straight through.
   assign bus.write_data   = (r_state == WRITE) ? bus.read_data : '0;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.words_done   = r_words_done;
   assign bus.enable_read  = r_en_rd;
   assign bus.enable_write = r_en_wr;
   assign bus.ram_addr     = r_ram_addr;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a synchronous 256x8 memory plus an
// array-level reference copy model; every copy is compared cycle by cycle and at the end.
module tb_mem_copy_engine;

   logic       clk;
   logic       rst_n;
   logic       tb_we;
   logic [7:0] tb_wa;
   logic [7:0] tb_wd;
   logic [7:0] r_rd;
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   logic [7:0] rd_q[$];
   logic [7:0] wr_q[$];
   int         pass_cnt;
   int         total_cnt;

   mem_copy_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   mem_copy_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   assign bus.read_data = r_rd;

   always #5 clk = ~clk;

   // Data memory: bench loads take priority, reads return on the next edge.
   always @(posedge clk) begin
      if (tb_we) mem[tb_wa] <= tb_wd;
      else if (bus.enable_write) mem[bus.ram_addr] <= bus.write_data;
      if (bus.enable_read) r_rd <= mem[bus.ram_addr];
   end

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = v;
      ref_mem[a] = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         tb_we = 1'b1; tb_wa = 8'(i); tb_wd = 8'($urandom);
         ref_mem[i] = tb_wd;
      end
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Reference semantics: words copied one at a time in ascending order.
   task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) ref_mem[8'(d + i)] = ref_mem[8'(s + i)];
   endtask

   function automatic int mem_diff();
      int cnt = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) cnt++;
      return cnt;
   endfunction

   function automatic bit seq_ok(input logic [7:0] q[$], input logic [7:0] base, input int n);
      if (q.size() != n) return 1'b0;
      for (int i = 0; i < n; i++) if (q[i] !== 8'(base + i)) return 1'b0;
      return 1'b1;
   endfunction

   // Runs one copy; done_cyc is the cycle (1 = right after the sampling edge) where done is seen.
   task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                          input bit start_in_done, output int done_cyc);
      bit ok;
      rd_q.delete(); wr_q.delete();
      done_cyc = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.length = n;
      @(negedge clk);
      bus.start = 1'b0;
      bus.src_addr = 8'($urandom); bus.dst_addr = 8'($urandom);
      bus.length = 9'($urandom_range(0, 256));
      for (int c = 1; c <= 600; c++) begin
         if (c > 1) @(negedge clk);
         ok = !(bus.enable_read && bus.enable_write)
              && (bus.busy === (bus.enable_read || bus.enable_write))
              && ((bus.enable_read || bus.enable_write)
                  || (bus.ram_addr === 8'h00 && bus.write_data === 8'h00));
         total_cnt++;
         if (ok) pass_cnt++;
         else $display("FAIL cycle_invariant c=%0d: rd=%b wr=%b busy=%b addr=%h wdata=%h, want exclusive strobes, busy=rd|wr, zero bus when idle",
                       c, bus.enable_read, bus.enable_write, bus.busy, bus.ram_addr, bus.write_data);
         if (bus.enable_read)  rd_q.push_back(bus.ram_addr);
         if (bus.enable_write) wr_q.push_back(bus.ram_addr);
         if (bus.done === 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      total_cnt++;
      if (done_cyc > 0) pass_cnt++;
      else $display("FAIL done_timeout: done not seen within 600 cycles, want it by cycle %0d", 2 * n + 1);
      if (start_in_done) begin
         bus.start = 1'b1; bus.src_addr = 8'h00; bus.dst_addr = 8'hC0; bus.length = 9'd5;
      end
      @(negedge clk);
      bus.start = 1'b0;
      total_cnt++;
      if (bus.done === 1'b0) pass_cnt++;
      else $display("FAIL done_pulse_width: done=%b one cycle after pulse, want 0", bus.done);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b1; bus.src_addr = 8'h33; bus.dst_addr = 8'h44; bus.length = 9'd5;
      repeat (3) @(negedge clk);
      total_cnt += 7;
      if (bus.busy === 1'b0) pass_cnt++; else $display("FAIL reset_busy: got %b want 0", bus.busy);
      if (bus.done === 1'b0) pass_cnt++; else $display("FAIL reset_done: got %b want 0", bus.done);
      if (bus.enable_read === 1'b0) pass_cnt++; else $display("FAIL reset_en_rd: got %b want 0", bus.enable_read);
      if (bus.enable_write === 1'b0) pass_cnt++; else $display("FAIL reset_en_wr: got %b want 0", bus.enable_write);
      if (bus.ram_addr === 8'h00) pass_cnt++; else $display("FAIL reset_addr: got %h want 00", bus.ram_addr);
      if (bus.write_data === 8'h00) pass_cnt++; else $display("FAIL reset_wdata: got %h want 00", bus.write_data);
      if (bus.words_done === 9'd0) pass_cnt++; else $display("FAIL reset_words_done: got %0d want 0", bus.words_done);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (bus.busy === 1'b0 && bus.enable_read === 1'b0) pass_cnt++;
      else $display("FAIL reset_release_idle: busy=%b rd=%b want 0/0", bus.busy, bus.enable_read);
   endtask

   task automatic test_basic_copy();
      int dc;
      fill_random();
      poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
      do_copy(8'h10, 8'h80, 9'd4, 1'b0, dc);
      model_copy(8'h10, 8'h80, 4);
      total_cnt += 5;
      if (dc == 9) pass_cnt++; else $display("FAIL basic_latency: done at cycle %0d want 9", dc);
      if (bus.words_done === 9'd4) pass_cnt++; else $display("FAIL basic_words_done: got %0d want 4", bus.words_done);
      if (mem[8'h80] === 8'hA1 && mem[8'h81] === 8'hB2 && mem[8'h82] === 8'hC3 && mem[8'h83] === 8'hD4) pass_cnt++;
      else $display("FAIL basic_dest: got %h %h %h %h want A1 B2 C3 D4", mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
      if (mem_diff() == 0) pass_cnt++; else $display("FAIL basic_mem: %0d words differ from model, want 0", mem_diff());
      repeat (4) @(negedge clk);
      if (bus.words_done === 9'd4) pass_cnt++; else $display("FAIL basic_words_hold: got %0d want 4", bus.words_done);
   endtask

   task automatic test_zero_length();
      int dc;
      do_copy(8'h10, 8'h90, 9'd0, 1'b0, dc);
      total_cnt += 3;
      if (dc == 1) pass_cnt++; else $display("FAIL zero_latency: done at cycle %0d want 1", dc);
      if (rd_q.size() == 0 && wr_q.size() == 0) pass_cnt++;
      else $display("FAIL zero_strobes: reads=%0d writes=%0d want 0/0", rd_q.size(), wr_q.size());
      if (bus.words_done === 9'd0) pass_cnt++; else $display("FAIL zero_words_done: got %0d want 0", bus.words_done);
   endtask

   task automatic test_wrap();
      int dc;
      do_copy(8'hFE, 8'h02, 9'd3, 1'b0, dc);
      model_copy(8'hFE, 8'h02, 3);
      total_cnt += 4;
      if (rd_q.size() == 3 && rd_q[0] === 8'hFE && rd_q[1] === 8'hFF && rd_q[2] === 8'h00) pass_cnt++;
      else $display("FAIL wrap_reads: got %p want FE FF 00", rd_q);
      if (wr_q.size() == 3 && wr_q[0] === 8'h02 && wr_q[1] === 8'h03 && wr_q[2] === 8'h04) pass_cnt++;
      else $display("FAIL wrap_writes: got %p want 02 03 04", wr_q);
      if (dc == 7) pass_cnt++; else $display("FAIL wrap_latency: done at cycle %0d want 7", dc);
      if (mem_diff() == 0) pass_cnt++; else $display("FAIL wrap_mem: %0d words differ from model, want 0", mem_diff());
   endtask

   task automatic test_overlap();
      int dc;
      poke(8'h20, 8'h55); poke(8'h21, 8'h11); poke(8'h22, 8'h22); poke(8'h23, 8'h33);
      do_copy(8'h20, 8'h21, 9'd3, 1'b0, dc);
      model_copy(8'h20, 8'h21, 3);
      total_cnt += 2;
      if (mem[8'h21] === 8'h55 && mem[8'h22] === 8'h55 && mem[8'h23] === 8'h55) pass_cnt++;
      else $display("FAIL overlap_dest: got %h %h %h want 55 55 55", mem[8'h21], mem[8'h22], mem[8'h23]);
      if (mem_diff() == 0) pass_cnt++; else $display("FAIL overlap_mem: %0d words differ from model, want 0", mem_diff());
   endtask

   task automatic test_random();
      int dc;
      logic [7:0] s, d;
      int n;
      for (int t = 0; t < 8; t++) begin
         s = 8'($urandom); d = 8'($urandom);
         n = (t == 0) ? 256 : int'($urandom_range(0, 24));
         do_copy(s, d, 9'(n), 1'b0, dc);
         model_copy(s, d, n);
         total_cnt += 5;
         if (dc == ((n == 0) ? 1 : 2 * n + 1)) pass_cnt++;
         else $display("FAIL rand%0d_latency: done at cycle %0d want %0d", t, dc, (n == 0) ? 1 : 2 * n + 1);
         if (bus.words_done === 9'(n)) pass_cnt++;
         else $display("FAIL rand%0d_words_done: got %0d want %0d", t, bus.words_done, n);
         if (seq_ok(rd_q, s, n)) pass_cnt++;
         else $display("FAIL rand%0d_read_order: %0d reads, want %0d ascending from %h", t, rd_q.size(), n, s);
         if (seq_ok(wr_q, d, n)) pass_cnt++;
         else $display("FAIL rand%0d_write_order: %0d writes, want %0d ascending from %h", t, wr_q.size(), n, d);
         if (mem_diff() == 0) pass_cnt++;
         else $display("FAIL rand%0d_mem: %0d words differ from model, want 0", t, mem_diff());
      end
   endtask

   task automatic test_back_to_back();
      int dc;
      bit quiet;
      do_copy(8'h05, 8'h60, 9'd2, 1'b1, dc);
      model_copy(8'h05, 8'h60, 2);
      quiet = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.enable_read !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
      end
      total_cnt += 3;
      if (quiet) pass_cnt++; else $display("FAIL b2b_start_in_done: engine left IDLE, want start in DONE ignored");
      do_copy(8'h60, 8'h70, 9'd2, 1'b0, dc);
      model_copy(8'h60, 8'h70, 2);
      if (dc == 5) pass_cnt++; else $display("FAIL b2b_latency: done at cycle %0d want 5", dc);
      if (mem_diff() == 0) pass_cnt++; else $display("FAIL b2b_mem: %0d words differ from model, want 0", mem_diff());
   endtask

   task automatic test_busy_start_and_abort();
      int nw = 0;
      bit aborted = 1'b0;
      bit quiet = 1'b1;
      bit ok;
      rd_q.delete(); wr_q.delete();
      @(negedge clk);
      bus.start = 1'b1; bus.src_addr = 8'h40; bus.dst_addr = 8'h90; bus.length = 9'd8;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         ok = !(bus.enable_read && bus.enable_write)
              && (bus.busy === (bus.enable_read || bus.enable_write));
         total_cnt++;
         if (ok) pass_cnt++;
         else $display("FAIL abort_cycle_invariant c=%0d: rd=%b wr=%b busy=%b", c, bus.enable_read, bus.enable_write, bus.busy);
         if (bus.enable_read)  rd_q.push_back(bus.ram_addr);
         if (bus.enable_write) wr_q.push_back(bus.ram_addr);
         if (c == 3) begin
            bus.start = 1'b1; bus.src_addr = 8'h00; bus.dst_addr = 8'h00; bus.length = 9'd1;
         end else bus.start = 1'b0;
         if (bus.enable_write) nw++;
         if (nw == 2) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            total_cnt += 3;
            if (bus.enable_read === 1'b0 && bus.enable_write === 1'b0) pass_cnt++;
            else $display("FAIL abort_strobes: rd=%b wr=%b want 0/0 during reset", bus.enable_read, bus.enable_write);
            if (bus.busy === 1'b0 && bus.done === 1'b0) pass_cnt++;
            else $display("FAIL abort_status: busy=%b done=%b want 0/0 during reset", bus.busy, bus.done);
            if (bus.ram_addr === 8'h00 && bus.write_data === 8'h00 && bus.words_done === 9'd0) pass_cnt++;
            else $display("FAIL abort_bus: addr=%h wdata=%h words=%0d want 00/00/0", bus.ram_addr, bus.write_data, bus.words_done);
            aborted = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (aborted) pass_cnt++; else $display("FAIL abort_second_write: saw %0d writes in 40 cycles, want 2", nw);
      model_copy(8'h40, 8'h90, 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.enable_read !== 1'b0 || bus.enable_write !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
      end
      total_cnt += 4;
      if (quiet) pass_cnt++; else $display("FAIL abort_no_resume: activity after reset release, want idle");
      if (rd_q.size() == 2 && rd_q[0] === 8'h40 && rd_q[1] === 8'h41) pass_cnt++;
      else $display("FAIL abort_reads: got %p want 40 41", rd_q);
      if (wr_q.size() == 2 && wr_q[0] === 8'h90 && wr_q[1] === 8'h91) pass_cnt++;
      else $display("FAIL abort_writes: got %p want 90 91", wr_q);
      if (mem_diff() == 0) pass_cnt++; else $display("FAIL abort_mem: %0d words differ from model, want 0", mem_diff());
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
      bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
      pass_cnt = 0; total_cnt = 0;
      test_reset();
      test_basic_copy();
      test_zero_length();
      test_wrap();
      test_overlap();
      test_random();
      test_back_to_back();
      test_busy_start_and_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
